// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared definitions for the configuration-chain loader: the FSM state
//   enum and the helper that sizes counters able to hold the value n.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Width of a counter that must represent 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Serialises configuration words into a configuration-flip-flop chain of
//   CHAIN_LEN bits, LSB of each word first. Words are taken over a
//   valid/ready handshake; the next word can be taken during the last bit
//   of the current one so a continuous supply gives bubble-free shifting.
//
// Ports
//   prog_clk    : clock, all state on rising edge
//   prog_reset  : synchronous active-high reset
//   start       : begin a load (honoured in IDLE / DONE only)
//   abort       : cancel a load in progress (WAIT_WORD / SHIFT only)
//   word_valid  : word_data is valid
//   word_data   : configuration word, bit 0 shifted first
//   word_ready  : loader takes word_data this cycle
//   ccff_head   : serial data into the chain head
//   shift_en    : chain advances this cycle
//   busy        : load in progress (WAIT_WORD or SHIFT)
//   done        : chain fully loaded
//   bit_count   : bits shifted in the current or last load
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           word_valid,
    input  logic [WORD_W-1:0]              word_data,
    output logic                           word_ready,
    output logic                           ccff_head,
    output logic                           shift_en,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

    localparam int BC_W = cnt_w(CHAIN_LEN);
    localparam int BL_W = cnt_w(WORD_W);

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shift_reg;
    logic [BL_W-1:0]   bits_left;   // bits of the current word still to shift
    logic              last_bit;
    logic              final_bit;
    logic              xfer;
    logic [BC_W-1:0]   count_next;
    logic [BC_W-1:0]   room;
    logic [BL_W-1:0]   take;

    // ---------------- state register ----------------
    always_ff @(posedge prog_clk) begin
        if (prog_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = WAIT_WORD;
            end
            WAIT_WORD: begin
                if (abort)     state_nxt = IDLE;
                else if (xfer) state_nxt = SHIFT;
            end
            SHIFT: begin
                // abort outranks both the final-bit and the refill decision
                if (abort)          state_nxt = IDLE;
                else if (final_bit) state_nxt = DONE;
                else if (last_bit)  state_nxt = xfer ? SHIFT : WAIT_WORD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output / handshake logic ----------------
    always_comb begin
        last_bit   = (bits_left == BL_W'(1));
        final_bit  = (bit_count == BC_W'(CHAIN_LEN - 1));
        // an aborting cycle neither shifts nor accepts a word
        shift_en   = (state == SHIFT) && !abort;
        ccff_head  = shift_en & shift_reg[0];
        word_ready = !abort &&
                     ((state == WAIT_WORD) ||
                      ((state == SHIFT) && last_bit && !final_bit));
        xfer       = word_valid & word_ready;
        busy       = (state == WAIT_WORD) || (state == SHIFT);
        done       = (state == DONE);
    end

    // Bits a newly accepted word may contribute: limited by the room left in
    // the chain once this cycle's shift (if any) has been counted.
    always_comb begin
        count_next = bit_count + BC_W'(shift_en);
        room       = BC_W'(CHAIN_LEN) - count_next;
        if (32'(room) >= WORD_W) take = BL_W'(WORD_W);
        else                     take = BL_W'(room);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            shift_reg <= '0;
            bits_left <= '0;
            bit_count <= '0;
        end else begin
            if (((state == IDLE) || (state == DONE)) && start)
                bit_count <= '0;
            if (shift_en) begin
                bit_count <= count_next;
                shift_reg <= shift_reg >> 1;
                bits_left <= bits_left - BL_W'(1);
            end
            // a refill lands on the last bit of the previous word, so it
            // replaces the shifted value rather than racing with it
            if (xfer) begin
                shift_reg <= word_data;
                bits_left <= take;
            end
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    localparam int WW = 8;
    localparam int CL = 20;

    logic          prog_clk = 0;
    logic          prog_reset = 0;
    logic          start = 0;
    logic          abort = 0;
    logic          word_valid = 0;
    logic [WW-1:0] word_data = '0;
    logic          word_ready, ccff_head, shift_en, busy, done;
    logic [4:0]    bit_count;

    int n_checks = 0;
    int n_fail   = 0;

    ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .start      (start),
        .abort      (abort),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .ccff_head  (ccff_head),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done),
        .bit_count  (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // word source and observed chain stream
    logic [WW-1:0] wq[$];
    bit            obs[$];

    int drv_shifts, drv_xfers, drv_wait, drv_first, drv_last, drv_stall_bad;
    int drv_bc0;
    bit drv_timeout;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Reference: the chain receives the words' bits LSB first, back to back,
    // cut off after CL bits regardless of handshake timing.
    function automatic logic [CL-1:0] exp_stream();
        logic [CL-1:0] v;
        int n;
        v = '0;
        n = 0;
        foreach (wq[w])
            for (int b = 0; b < WW; b++)
                if (n < CL) begin
                    v[n] = wq[w][b];
                    n++;
                end
        return v;
    endfunction

    function automatic logic [CL-1:0] obs_stream();
        logic [CL-1:0] v;
        v = '0;
        foreach (obs[i]) if (i < CL) v[i] = obs[i];
        return v;
    endfunction

    // Drives one load from IDLE/DONE. Inputs change 1 ns after the edge,
    // outputs are sampled 2 ns after the edge.
    task automatic drive_load(input int stall_after, input int stall_len,
                              input int abort_at, input int mid_start_at,
                              input bit rand_valid);
        int wi, stall_done;
        bit aborted, started_mid, stalling;
        wi = 0; stall_done = 0; aborted = 0; started_mid = 0;
        obs.delete();
        drv_shifts = 0; drv_xfers = 0; drv_wait = 0;
        drv_first = -1; drv_last = -1; drv_stall_bad = 0;
        start = 1;
        tick();
        start = 0;
        drv_bc0 = int'(bit_count);
        drv_timeout = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            stalling   = (wi == stall_after) && (stall_done < stall_len);
            word_valid = (wi < wq.size()) && !stalling &&
                         (!rand_valid || ($urandom_range(0, 3) != 0));
            word_data  = (wi < wq.size()) ? wq[wi] : '0;
            abort      = (abort_at >= 0) && busy && (int'(bit_count) == abort_at);
            start      = (mid_start_at >= 0) && !started_mid && busy &&
                         (int'(bit_count) == mid_start_at);
            if (start) started_mid = 1;
            #1;
            if (stalling && busy && !shift_en) begin
                stall_done++;
                if (int'(bit_count) != stall_after * WW) drv_stall_bad++;
            end
            if (shift_en) begin
                obs.push_back(ccff_head);
                drv_shifts++;
                if (drv_first < 0) drv_first = cyc;
                drv_last = cyc;
            end else if (busy) begin
                drv_wait++;
            end
            if (word_valid && word_ready) begin
                wi++;
                drv_xfers++;
            end
            if (abort) aborted = 1;
            @(posedge prog_clk);
            #1;
            word_valid = 0; abort = 0; start = 0;
            if (done || aborted) begin
                drv_timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        prog_reset = 1;
        tick(); tick();
        #1;
        n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL reset_word_ready got=%b exp=0", word_ready); end
        n_checks++; if (ccff_head !== 1'b0) begin n_fail++; $display("FAIL reset_ccff_head got=%b exp=0", ccff_head); end
        n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL reset_shift_en got=%b exp=0", shift_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (bit_count !== 5'd0) begin n_fail++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
        prog_reset = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        wq = '{8'hA5, 8'h3C, 8'hFF};
        drive_load(-1, 0, -1, -1, 0);
        n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got=%b exp=0", drv_timeout); end
        n_checks++; if (drv_bc0 != 0) begin n_fail++; $display("FAIL b2b_bc_after_start got=%0d exp=0", drv_bc0); end
        n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
            begin n_fail++; $display("FAIL b2b_stream got=%05h/%0d exp=%05h/%0d", obs_stream(), obs.size(), exp_stream(), CL); end
        n_checks++; if (drv_first != 1) begin n_fail++; $display("FAIL b2b_first_shift got=%0d exp=1", drv_first); end
        n_checks++; if (drv_last - drv_first + 1 != CL) begin n_fail++; $display("FAIL b2b_contiguous got=%0d exp=%0d", drv_last - drv_first + 1, CL); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", done); end
        n_checks++; if (bit_count !== 5'(CL)) begin n_fail++; $display("FAIL b2b_bit_count got=%0d exp=%0d", bit_count, CL); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got=%b exp=0", busy); end
    endtask

    task automatic test_truncation();
        wq = '{8'hA5, 8'h3C, 8'h0F, 8'h77};
        drive_load(-1, 0, -1, -1, 0);
        n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
            begin n_fail++; $display("FAIL trunc_stream got=%05h/%0d exp=%05h/%0d", obs_stream(), obs.size(), exp_stream(), CL); end
        n_checks++; if (drv_xfers != 3) begin n_fail++; $display("FAIL trunc_xfers got=%0d exp=3", drv_xfers); end
        word_valid = 1;
        #1;
        n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL trunc_ready_in_done got=%b exp=0", word_ready); end
        word_valid = 0;
        n_checks++; if (bit_count !== 5'(CL)) begin n_fail++; $display("FAIL trunc_bit_count got=%0d exp=%0d", bit_count, CL); end
    endtask

    task automatic test_stall();
        wq = '{8'hA5, 8'h3C, 8'hFF};
        drive_load(1, 5, -1, -1, 0);
        n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
            begin n_fail++; $display("FAIL stall_stream got=%05h/%0d exp=%05h/%0d", obs_stream(), obs.size(), exp_stream(), CL); end
        // initial wait + 5 stalled + the cycle that finally transfers
        n_checks++; if (drv_wait != 7) begin n_fail++; $display("FAIL stall_wait_cycles got=%0d exp=7", drv_wait); end
        n_checks++; if (drv_stall_bad != 0) begin n_fail++; $display("FAIL stall_bit_count_hold got=%0d bad exp=0", drv_stall_bad); end
        n_checks++; if (drv_shifts != CL) begin n_fail++; $display("FAIL stall_shift_cycles got=%0d exp=%0d", drv_shifts, CL); end
    endtask

    task automatic test_abort();
        wq = '{8'hA5, 8'h3C, 8'hFF};
        drive_load(-1, 0, 11, -1, 0);
        n_checks++; if (obs.size() != 11) begin n_fail++; $display("FAIL abort_bits_shifted got=%0d exp=11", obs.size()); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL abort_shift_en got=%b exp=0", shift_en); end
        n_checks++; if (bit_count !== 5'd11) begin n_fail++; $display("FAIL abort_bit_count got=%0d exp=11", bit_count); end
        wq = '{8'h5A, 8'hC3, 8'h81};
        drive_load(-1, 0, -1, -1, 0);
        n_checks++; if (drv_bc0 != 0) begin n_fail++; $display("FAIL abort_restart_clear got=%0d exp=0", drv_bc0); end
        n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
            begin n_fail++; $display("FAIL abort_restart_stream got=%05h/%0d exp=%05h/%0d", obs_stream(), obs.size(), exp_stream(), CL); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_restart_done got=%b exp=1", done); end
    endtask

    task automatic test_reset_mid_shift();
        start = 1;
        tick();
        start = 0;
        word_valid = 1;
        word_data  = 8'($urandom);
        for (int i = 0; i < 50 && bit_count != 5'd6; i++) tick();
        n_checks++; if (bit_count !== 5'd6) begin n_fail++; $display("FAIL rst_mid_reach got=%0d exp=6", bit_count); end
        prog_reset = 1;
        start      = 1;
        tick();
        n_checks++; if (shift_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_shift_en got=%b exp=0", shift_en); end
        n_checks++; if (ccff_head !== 1'b0) begin n_fail++; $display("FAIL rst_mid_head got=%b exp=0", ccff_head); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_done got=%b%b exp=00", busy, done); end
        n_checks++; if (word_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=0", word_ready); end
        n_checks++; if (bit_count !== 5'd0) begin n_fail++; $display("FAIL rst_mid_bit_count got=%0d exp=0", bit_count); end
        prog_reset = 0;
        start      = 0;
        tick();
        n_checks++; if (busy !== 1'b0 || shift_en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start_ignored got=%b%b exp=00", busy, shift_en); end
        word_valid = 0;
    endtask

    task automatic test_ignored_inputs();
        wq = '{8'h96, 8'h1E, 8'hE7};
        drive_load(-1, 0, -1, 5, 0);
        n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
            begin n_fail++; $display("FAIL ign_start_stream got=%05h/%0d exp=%05h/%0d", obs_stream(), obs.size(), exp_stream(), CL); end
        abort = 1;
        tick();
        abort = 0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_abort_done got=%b exp=1", done); end
        n_checks++; if (bit_count !== 5'(CL)) begin n_fail++; $display("FAIL ign_abort_bit_count got=%0d exp=%0d", bit_count, CL); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_abort_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            wq.delete();
            for (int w = 0; w < 4; w++) wq.push_back(WW'($urandom));
            drive_load(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), -1, -1, 1);
            n_checks++; if (drv_timeout !== 1'b0) begin n_fail++; $display("FAIL rand_timeout it=%0d got=%b exp=0", it, drv_timeout); end
            n_checks++; if (obs_stream() !== exp_stream() || obs.size() != CL)
                begin n_fail++; $display("FAIL rand_stream it=%0d got=%05h/%0d exp=%05h/%0d", it, obs_stream(), obs.size(), exp_stream(), CL); end
            n_checks++; if (drv_xfers != 3) begin n_fail++; $display("FAIL rand_xfers it=%0d got=%0d exp=3", it, drv_xfers); end
            n_checks++; if (bit_count !== 5'(CL) || done !== 1'b1)
                begin n_fail++; $display("FAIL rand_end it=%0d got=%0d/%b exp=%0d/1", it, bit_count, done, CL); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_truncation();
        test_stall();
        test_abort();
        test_reset_mid_shift();
        test_ignored_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of each configuration word accepted.
REQ-002 SHALL have parameter CHAIN_LEN, default 1024, total bits in the target configuration-flip-flop chain (CHAIN_LEN >= 1).
REQ-003 SHALL have port prog_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port prog_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a chain load; sampled only in IDLE or DONE.
REQ-006 SHALL have port abort  input  1  cancel an in-progress load.
REQ-007 SHALL have port word_valid  input  1  word_data holds a valid configuration word.
REQ-008 SHALL have port word_data  input  WORD_W  configuration word; bit 0 is shifted first.
REQ-009 SHALL have port word_ready  output  1  loader accepts word_data this cycle.
REQ-010 SHALL have port ccff_head  output  1  serial data into the chain head.
REQ-011 SHALL have port shift_en  output  1  chain advances one position this cycle.
REQ-012 SHALL have port busy  output  1  high in WAIT_WORD and SHIFT.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port bit_count  output  $clog2(CHAIN_LEN+1)  bits shifted in the current or last load.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_WORD, SHIFT, DONE.
REQ-016 IDLE/DONE with start=1 SHALL go to WAIT_WORD next cycle and clear bit_count to 0; start is ignored in all other states.
REQ-017 word_ready SHALL be 1 in WAIT_WORD, and in SHIFT only during the last bit of the current word when that bit is not the final chain bit; 0 otherwise.
REQ-018 A transfer occurs when word_valid & word_ready; the word SHALL be loaded into the shift register and the next cycle SHALL be SHIFT.
REQ-019 Bits taken from a word SHALL be min(WORD_W, CHAIN_LEN - bit_count at acceptance); excess upper bits are discarded.
REQ-020 In SHIFT, each cycle SHALL drive shift_en=1, ccff_head=shift_reg[0], shift the register right by one, and increment bit_count.
REQ-021 On the last bit of a word: if it is bit CHAIN_LEN-1 -> DONE; else if a transfer occurs -> remain in SHIFT with no bubble; else -> WAIT_WORD.
REQ-022 Outside SHIFT, shift_en SHALL be 0 and ccff_head SHALL be 0; a stall in WAIT_WORD is legal and unbounded.
REQ-023 bit_count SHALL never exceed CHAIN_LEN and SHALL hold its final value through DONE and IDLE until the next start.
REQ-024 abort=1 in WAIT_WORD or SHIFT SHALL go to IDLE next cycle, with shift_en=0 that cycle, no transfer accepted, and done not asserted; abort has priority over the transfer and the last-bit decision.
REQ-025 abort in IDLE or DONE SHALL be ignored.
REQ-026 done SHALL stay 1 until start (-> WAIT_WORD) or abort is ignored; it SHALL not pulse.
REQ-027 Latency: first shift_en SHALL occur the cycle after the first transfer.
REQ-028 Load time for N = CHAIN_LEN SHALL be N shift cycles plus stall cycles.

Reset
REQ-029 prog_reset SHALL force state IDLE, shift register 0, bit_count 0, and word_ready, ccff_head, shift_en, busy, done all 0 on the next edge.
REQ-030 prog_reset SHALL override start, abort and transfers in the same cycle, including mid-load; no residual shift_en SHALL follow.

Structure
REQ-031 The FSM state enum and a bit-count width function SHALL live in shared package ccff_loader_pkg.
REQ-032 SHALL be a single module with no sub-modules; shift register, counter and FSM are inline.

Verification (WORD_W=8, CHAIN_LEN=20)
REQ-033 Back-to-back: start, words 0xA5, 0x3C, 0xFF always valid -> ccff_head = 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, then 1,1,1,1 on 20 consecutive shift_en cycles; done=1 and bit_count=20.
REQ-034 Truncation: third word 0x0F -> only 4 bits (1,1,1,1) shifted and upper nibble discarded; word_ready=0 after the third transfer.
REQ-035 Stall: word_valid low for 5 cycles between words 1 and 2 -> shift_en=0 for those cycles; bit_count holds at 8; the output sequence is unchanged.
REQ-036 Abort at bit_count=11 -> IDLE next cycle; shift_en=0; done=0; bit_count=11; a new start clears bit_count to 0 and loads cleanly.
REQ-037 prog_reset asserted mid-SHIFT -> all outputs 0 next cycle; start asserted in the reset cycle is ignored.
REQ-038 start asserted while busy and abort asserted in DONE -> no effect on state, bit_count or done.
